// File: rtl/alu_muldiv_seq_if.sv
// ALU operand/select/result bus between the MULT/DIV sequencer (master) and an ALU (slave).
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             alu_z;

    modport master (
        output alu_a,
        output alu_b,
        output alu_sel,
        input  alu_res,
        input  alu_z
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_sel,
        output alu_res,
        output alu_z
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer driving a shared ALU: shift-add multiply, restoring divide.
// Define MULDIV_SIGNED_EN to add op_signed and a one-cycle NEG state for two's-complement MULT/DIV.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_div,
`ifdef MULDIV_SIGNED_EN
    input  logic                 op_signed,
`endif
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    alu_muldiv_seq_if.master     alu
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
`ifdef MULDIV_SIGNED_EN
    localparam logic [1:0] S_NEG  = 2'd3;
`endif

    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_div_reg;
    logic [WIDTH-1:0] acc_reg;      // multiply: running high half; divide: partial remainder
    logic [WIDTH-1:0] lo_sr_reg;    // multiply: multiplier / low half; divide: dividend / quotient
    logic [WIDTH-1:0] opnd_reg;     // multiplicand or divisor, fixed for the whole run
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             dz_reg;
`ifdef MULDIV_SIGNED_EN
    logic             neg_lo_reg;
    logic             neg_hi_reg;
`endif

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_by_zero;
    logic             last_iter;

    logic [WIDTH-1:0] shifted;
    logic             top;
    logic             ge;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] lo_sr_next;
    logic             unused_alu_z;

`ifdef MULDIV_SIGNED_EN
    logic             sa;
    logic             sb;
    logic [2*WIDTH-1:0] prod_neg;

    // Signed operands are run through the unsigned datapath as magnitudes.
    assign sa       = op_signed & op_a[WIDTH-1];
    assign sb       = op_signed & op_b[WIDTH-1];
    assign mag_a    = sa ? ('0 - op_a) : op_a;
    assign mag_b    = sb ? ('0 - op_b) : op_b;
    assign prod_neg = '0 - {acc_reg, lo_sr_reg};
`else
    assign mag_a    = op_a;
    assign mag_b    = op_b;
`endif

    assign div_by_zero = op_div && (op_b == '0);
    assign last_iter   = (cnt_reg == CNT_W'(WIDTH - 1));

    // Divide step: shift the next dividend bit into the remainder and trial-subtract.
    assign shifted = {acc_reg[WIDTH-2:0], lo_sr_reg[WIDTH-1]};
    assign top     = acc_reg[WIDTH-1];
    assign ge      = top | (shifted >= opnd_reg);

    // Multiply step: the ALU has no carry-out, so recover it from the wrapped sum.
    assign sum     = lo_sr_reg[0] ? alu.alu_res : acc_reg;
    assign carry   = lo_sr_reg[0] & (alu.alu_res < acc_reg);

    assign acc_next   = is_div_reg ? (ge ? alu.alu_res : shifted) : {carry, sum[WIDTH-1:1]};
    assign lo_sr_next = is_div_reg ? {lo_sr_reg[WIDTH-2:0], ge} : {sum[0], lo_sr_reg[WIDTH-1:1]};

    assign alu.alu_a   = (state_reg == S_RUN) ? (is_div_reg ? shifted : acc_reg) : '0;
    assign alu.alu_b   = (state_reg == S_RUN) ? opnd_reg : '0;
    assign alu.alu_sel = (state_reg == S_RUN && is_div_reg) ? SEL_SUB : SEL_ADD;
    assign unused_alu_z = alu.alu_z;

    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign div_zero = dz_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            acc_reg    <= '0;
            lo_sr_reg  <= '0;
            opnd_reg   <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dz_reg     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        is_div_reg <= op_div;
                        cnt_reg    <= '0;
                        acc_reg    <= '0;
                        lo_sr_reg  <= op_div ? mag_a : mag_b;
                        opnd_reg   <= op_div ? mag_b : mag_a;
                        dz_reg     <= div_by_zero;
`ifdef MULDIV_SIGNED_EN
                        neg_lo_reg <= sa ^ sb;
                        neg_hi_reg <= op_div ? sa : (sa ^ sb);
`endif
                        if (div_by_zero) begin
                            hi_reg    <= '0;
                            lo_reg    <= '0;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_reg   <= acc_next;
                    lo_sr_reg <= lo_sr_next;
                    if (last_iter) begin
                        cnt_reg <= '0;
`ifdef MULDIV_SIGNED_EN
                        state_reg <= S_NEG;
`else
                        hi_reg    <= acc_next;
                        lo_reg    <= lo_sr_next;
                        state_reg <= S_DONE;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef MULDIV_SIGNED_EN
                S_NEG: begin
                    // Quotient and remainder take separate signs; the product negates as one 64-bit value.
                    if (is_div_reg) begin
                        lo_reg <= neg_lo_reg ? ('0 - lo_sr_reg) : lo_sr_reg;
                        hi_reg <= neg_hi_reg ? ('0 - acc_reg) : acc_reg;
                    end else if (neg_lo_reg) begin
                        {hi_reg, lo_reg} <= prod_neg;
                    end else begin
                        {hi_reg, lo_reg} <= {acc_reg, lo_sr_reg};
                    end
                    state_reg <= S_DONE;
                end
`endif
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed MULTU/DIVU vectors, arithmetic reference model.
module tb_alu_muldiv_seq;
    localparam int WIDTH = 32;
`ifdef MULDIV_SIGNED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = WIDTH + 1 + EXTRA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op_div = 1'b0;
    logic        op_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    alu_muldiv_seq_if #(.WIDTH(WIDTH)) alu_bus ();

    // Plain behavioural ALU: ADD / SUB only.
    assign alu_bus.alu_res = (alu_bus.alu_sel == 3'b001) ? (alu_bus.alu_a - alu_bus.alu_b)
                                                         : (alu_bus.alu_a + alu_bus.alu_b);
    assign alu_bus.alu_z   = (alu_bus.alu_res == '0);

    alu_muldiv_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_div   (op_div),
`ifdef MULDIV_SIGNED_EN
        .op_signed(op_signed),
`endif
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo),
        .alu      (alu_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // {hi, lo} from plain arithmetic on the operands.
    function automatic logic [63:0] ref_result(input logic div, input logic sgn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (div) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end else begin
                q = sa * sb;
                res = q;
            end
        end else if (div) begin
            res = {a % b, a / b};
        end else begin
            res = {32'd0, a} * {32'd0, b};
        end
        return res;
    endfunction

    // Reference model: cycles remaining until done, and the results it will show.
    int          remain;
    logic        m_done, m_dz, m_div;
    logic [31:0] m_hi, m_lo, m_opnd, p_hi, p_lo;
    logic        m_busy;
    logic        m_sgn;

    assign m_sgn  = op_signed && (EXTRA == 1);
    assign m_busy = (remain != 0) || m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remain <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_div  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_opnd <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (remain != 0) begin
            remain <= remain - 1;
            if (remain == 1) begin
                m_done <= 1'b1;
                m_hi   <= p_hi;
                m_lo   <= p_lo;
            end
        end else if (start) begin
            m_div <= op_div;
            if (op_div && op_b == 32'd0) begin
                m_done <= 1'b1;
                m_hi   <= '0;
                m_lo   <= '0;
                m_dz   <= 1'b1;
            end else begin
                remain       <= WIDTH + EXTRA;
                m_dz         <= 1'b0;
                {p_hi, p_lo} <= ref_result(op_div, m_sgn, op_a, op_b);
                m_opnd       <= op_div ? mag(op_b, m_sgn) : mag(op_a, m_sgn);
            end
        end
    end

    // Compare process: every cycle once out of the initial reset.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy || m_done) begin
                chk("hi", hi, m_hi);
                chk("lo", lo, m_lo);
                chk("div_zero", div_zero, m_dz);
                chk("alu_a_idle", alu_bus.alu_a, 32'd0);
                chk("alu_b_idle", alu_bus.alu_b, 32'd0);
                chk("alu_sel_idle", alu_bus.alu_sel, 3'b000);
            end else if (remain > EXTRA) begin
                chk("alu_sel_run", alu_bus.alu_sel, m_div ? 3'b001 : 3'b000);
                chk("alu_b_run", alu_bus.alu_b, m_opnd);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: timeout, done=%b after %0d cycles", done, n);
        end
    endtask

    task automatic run_op(input string name, input logic div, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int exp_lat);
        int n;
        @(negedge clk);
        op_div = div; op_signed = sgn; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_hi"}, hi, exp_hi);
        chk({name, "_lo"}, lo, exp_lo);
        chk({name, "_dz"}, div_zero, exp_dz);
        $display("%s: a=%h b=%h -> hi=%h lo=%h dz=%b latency=%0d", name, a, b, hi, lo, div_zero, n);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_alu_sel", alu_bus.alu_sel, 3'b000);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("multu_7x6",   1'b0, 1'b0, 32'd7,         32'd6,         32'd0,         32'h0000_002A, 1'b0, LAT);
        run_op("multu_max",   1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT);
        run_op("divu_100_7",  1'b1, 1'b0, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, LAT);
        run_op("divu_max_1",  1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, LAT);
        run_op("divu_3_10",   1'b1, 1'b0, 32'd3,         32'd10,        32'd3,         32'd0,         1'b0, LAT);
        run_op("divu_5_0",    1'b1, 1'b0, 32'd5,         32'd0,         32'd0,         32'd0,         1'b1, 1);
        run_op("multu_2x3",   1'b0, 1'b0, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, LAT);

        // start mid-run is ignored
        @(negedge clk);
        op_div = 1'b0; op_signed = 1'b0; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        op_div = 1'b1; op_a = 32'd9; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignore_mid_hi", hi, 32'd0);
        chk("ignore_mid_lo", lo, 32'h0000_002A);
        $display("ignore_mid_run: hi=%h lo=%h", hi, lo);

        // start held during the done cycle is taken only on the next (idle) cycle
        op_div = 1'b0; op_a = 32'd2; op_b = 32'd3; start = 1'b1;
        @(negedge clk);
        chk("start_at_done_busy", busy, 1'b0);
        @(negedge clk);
        chk("start_after_done_busy", busy, 1'b1);
        start = 1'b0;
        wait_done(n);
        chk("start_after_done_lo", lo, 32'd6);
        $display("start_after_done: hi=%h lo=%h", hi, lo);

        // asynchronous reset mid-run
        @(negedge clk);
        op_div = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_lo", lo, 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        $display("async_reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst",   1'b0, 1'b0, 32'd7,         32'd6,         32'd0,         32'h0000_002A, 1'b0, LAT);

`ifdef MULDIV_SIGNED_EN
        run_op("mult_m7x6",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, LAT);
        run_op("div_m7_2",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT);
        run_op("div_min_m1",  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, LAT);
        run_op("div_s_zero",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0,         32'd0,         32'd0,         1'b1, 1);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle MULT/DIV sequencer for the MIPS datapath.
- Acts as the initiator of the ALU operand/select/result interface: each cycle it drives operands and a select code into an ALU instance, and it consumes that ALU's res/z.
- Builds 64-bit HI/LO results by iteration: shift-add multiply, restoring divide.
- Sits beside the main datapath ALU. The control unit starts it, and it stalls the pipeline via busy.

Parameters:
- WIDTH, 32, operand/ALU data width; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_div  input  1  0 = MULTU, 1 = DIVU (latched with start).
- op_a  input  WIDTH  multiplicand / dividend.
- op_b  input  WIDTH  multiplier / divisor.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse when hi/lo are valid.
- div_zero  output  1  set at done when DIVU had op_b == 0.
- hi  output  WIDTH  MULTU: product[63:32]; DIVU: remainder.
- lo  output  WIDTH  MULTU: product[31:0]; DIVU: quotient.
- alu_a  output  WIDTH  operand A to ALU.
- alu_b  output  WIDTH  operand B to ALU.
- alu_sel  output  3  ALU select: 000 ADD, 001 SUB (only codes used).
- alu_res  input  WIDTH  ALU result (combinational, same cycle).
- alu_z  input  1  ALU zero flag; unused, reserved.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; busy = done = div_zero = 0; hi = lo = 0.
  - alu_a = alu_b = 0; alu_sel = 000; counter = 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 latches op_a, op_b, op_div; counter = 0; go to RUN.
  - Exception: DIVU with op_b == 0 goes directly to DONE with hi = lo = 0 and div_zero = 1.
- RUN: one iteration per clock, WIDTH iterations, then DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency:
  - Normal operation: done is high in the cycle WIDTH+1 clocks after the start edge (33 for WIDTH = 32).
  - Divide-by-zero: done is high one clock after the start edge.
- busy covers RUN and DONE. start is ignored while busy, with no queueing.
- start asserted in the same cycle done is high is ignored. It is accepted on the following cycle (IDLE).
- hi/lo/div_zero hold their values from DONE until the next accepted start. div_zero clears on acceptance.
- MULTU iteration (unsigned):
  - Registers: acc (WIDTH), carry bit, lo shift register initialised to op_b.
  - Drive alu_a = acc, alu_b = multiplicand, alu_sel = 000.
  - sum = (lo[0]) ? alu_res : acc.
  - c = lo[0] & (alu_res < acc), computed locally because the ALU provides no carry.
  - Next acc = {c, sum[WIDTH-1:1]}; next lo = {sum[0], lo[WIDTH-1:1]}.
- DIVU iteration (restoring, unsigned):
  - Registers: rem (WIDTH) initialised to 0, msb-out bit, quotient shift register initialised to op_a.
  - shifted = {rem[WIDTH-2:0], quo[WIDTH-1]}; top = rem[WIDTH-1].
  - Drive alu_a = shifted, alu_b = divisor, alu_sel = 001.
  - ge = top | (shifted >= divisor).
  - Next rem = ge ? alu_res : shifted (wrap-around modulo 2^WIDTH is correct when top = 1).
  - Next quo = {quo[WIDTH-2:0], ge}.
- End of run: hi = acc/rem, lo = lo/quo, registered on entry to DONE.
- ALU outputs in IDLE/DONE: alu_a = alu_b = 0, alu_sel = 000.
- Boundaries:
  - 0xFFFFFFFF * 0xFFFFFFFF must produce a correct carry on every iteration.
  - Divisor 1 and dividend < divisor are legal.
  - Counter terminates exactly at WIDTH-1 with no wrap.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- When defined:
  - Adds input op_signed (1 bit, latched with start), selecting MULT/DIV on two's-complement operands.
  - Operands are converted to magnitudes on acceptance.
  - State NEG (1 cycle) is inserted between RUN and DONE. It negates the product, or the quotient (sign = sa^sb) and the remainder (sign = sa), as needed.
  - Latency for all signed and unsigned operations becomes WIDTH+2.
  - Divide-by-zero behaviour is unchanged.
  - Special case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0.
- When undefined: no op_signed port, no NEG state, unsigned only, latency WIDTH+1.

Test Plan:
- MULTU 0x0000_0007 * 0x0000_0006 -> done at start+33; hi = 0, lo = 0x2A; alu_sel = 000 throughout RUN.
- MULTU 0xFFFF_FFFF * 0xFFFF_FFFF -> hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- DIVU 100 / 7 -> lo = 14, hi = 2, div_zero = 0. DIVU 0xFFFF_FFFF / 1 -> lo = 0xFFFF_FFFF, hi = 0.
- DIVU 5 / 0 -> done at start+1, hi = lo = 0, div_zero = 1. A later MULTU 2 * 3 clears div_zero and gives lo = 6.
- start pulsed at cycle 10 mid-RUN -> ignored; result unchanged. rst asserted at iteration 15 -> busy = done = 0 and hi = lo = 0 immediately (asynchronous). The next start runs normally.
- With MULDIV_SIGNED_EN: signed -7 * 6 -> hi = 0xFFFF_FFFF, lo = 0xFFFF_FFD6 at start+34. Signed -7 / 2 -> lo = 0xFFFF_FFFD, hi = 0xFFFF_FFFF.
